// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic array controller
package systolic_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int N_DEF  = 4;
  localparam int K_DEF  = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
endpackage

// File: rtl/feed_skew.sv
// feed_skew: per-lane zero-filled delay lines, lane i delayed i+1 cycles
module feed_skew
  import systolic_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [N*DATA_W-1:0] din,
  output logic [N*DATA_W-1:0] dout
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] sr_q [i+1];
    logic [DATA_W-1:0] sr_d [i+1];
    // stage 0 admits data only on valid beats so idle cycles feed zeros
    always_comb begin
      sr_d[0] = valid ? din[i*DATA_W +: DATA_W] : '0;
      for (int j = 1; j <= i; j++) sr_d[j] = sr_q[j-1];
    end
    // shift register with synchronous active-low clear
    always_ff @(posedge clk) begin
      if (!reset) sr_q <= '{default: '0};
      else sr_q <= sr_d;
    end
    assign dout[i*DATA_W +: DATA_W] = sr_q[i];
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences clear, operand feed and drain for an N x N MAC grid
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF,
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [KW-1:0]       k_addr,
  input  logic [N*DATA_W-1:0] a_rdata,
  input  logic [N*DATA_W-1:0] b_rdata,
  output logic [N*DATA_W-1:0] a_feed,
  output logic [N*DATA_W-1:0] b_feed,
  output logic                array_rst_n
);
  localparam int CW = $clog2(K + 2*N + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          last_feed, last_drain;
  assign last_feed  = cnt_q == CW'(K - 1);
  assign last_drain = cnt_q == CW'(2*N - 1);
  // outputs decoded from state; next state and beat/drain counter
  always_comb begin
    busy        = reset && state_q != IDLE;
    done        = reset && state_q == DONE;
    rd_en       = reset && state_q == FEED;
    array_rst_n = reset && state_q != CLEAR;
    k_addr      = rd_en ? cnt_q[KW-1:0] : '0;
    rvalid_d    = rd_en;
    state_d     = state_q;
    cnt_d       = '0;
    unique case (state_q)
      IDLE:  state_d = start ? CLEAR : IDLE;
      CLEAR: state_d = FEED;
      FEED: begin
        state_d = last_feed ? DRAIN : FEED;
        cnt_d   = last_feed ? '0 : cnt_q + 1'b1;
      end
      DRAIN: begin
        state_d = last_drain ? DONE : DRAIN;
        cnt_d   = last_drain ? '0 : cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, counter and read-return valid registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end
  feed_skew #(.N(N)) u_skew_a (
    .clk(clk), .reset(reset), .valid(rvalid_q), .din(a_rdata), .dout(a_feed)
  );
  feed_skew #(.N(N)) u_skew_b (
    .clk(clk), .reset(reset), .valid(rvalid_q), .din(b_rdata), .dout(b_feed)
  );
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: cycle model of the controller plus a MAC grid fed by the DUT
module tb_systolic_ctrl;
  import systolic_pkg::*;
  localparam int N = 4, K = 4, L = K + 2*N + 2;
  logic clk = 0, reset = 0, start = 0, start1 = 0;
  logic busy, done, rd_en, arst;
  logic [1:0] k_addr;
  logic [N*8-1:0] a_rdata = '0, b_rdata = '0, a_feed, b_feed;
  logic busy1, done1, rd_en1, arst1, k_addr1;
  logic [N*8-1:0] a_feed1, b_feed1, ones = '1;
  logic [N*8-1:0] mem_a [K], mem_b [K], ja [K], jb [K];
  int cyc = 0, n_pass = 0, n_tot = 0, m_s = 0;
  bit run = 0, m_v = 0;
  logic rd_pend = 0;
  logic [1:0] k_pend = 0;

  systolic_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .k_addr(k_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_feed(a_feed), .b_feed(b_feed), .array_rst_n(arst)
  );
  systolic_ctrl #(.N(N), .K(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .k_addr(k_addr1), .a_rdata(ones), .b_rdata(ones),
    .a_feed(a_feed1), .b_feed(b_feed1), .array_rst_n(arst1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
  endfunction

  // operand buffer: data for the read issued last cycle, noise otherwise
  always @(negedge clk) begin
    rd_pend = rd_en;
    k_pend  = k_addr;
  end
  always @(posedge clk) begin
    #1;
    a_rdata = rd_pend ? mem_a[k_pend] : $urandom;
    b_rdata = rd_pend ? mem_b[k_pend] : $urandom;
  end

  // unsigned int8 MAC grid: A flows right, B flows down
  logic [N*8-1:0] gaf [2], gbf [2];
  logic gar [2];
  assign gaf[0] = a_feed;  assign gbf[0] = b_feed;  assign gar[0] = arst;
  assign gaf[1] = a_feed1; assign gbf[1] = b_feed1; assign gar[1] = arst1;
  for (genvar g = 0; g < 2; g++) begin : g_grid
    logic [7:0] ah [N][N];
    logic [7:0] bv [N][N];
    logic [ACC_W-1:0] acc [N][N];
    always @(posedge clk) begin
      logic [7:0] ai, bi;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ai = (c == 0) ? gaf[g][8*r +: 8] : ah[r][c > 0 ? c - 1 : 0];
          bi = (r == 0) ? gbf[g][8*c +: 8] : bv[r > 0 ? r - 1 : 0][c];
          if (!gar[g]) begin
            acc[r][c] <= '0; ah[r][c] <= '0; bv[r][c] <= '0;
          end else begin
            acc[r][c] <= acc[r][c] + {8'h0, ai} * {8'h0, bi};
            ah[r][c] <= ai; bv[r][c] <= bi;
          end
        end
    end
  end

  // job-timeline model: everything derives from the cycle start was taken
  always @(negedge clk) if (run) begin
    int t, ta;
    bit in_job;
    logic [N*8-1:0] ea, eb;
    t = cyc - m_s;
    in_job = m_v && t >= 1 && t <= L;
    chk("busy", busy, reset && in_job);
    chk("done", done, reset && m_v && t == L);
    chk("array_rst_n", arst, reset && !(m_v && t == 1));
    chk("rd_en", rd_en, reset && m_v && t >= 2 && t <= K + 1);
    chk("k_addr", k_addr, (reset && m_v && t >= 2 && t <= K + 1) ? t - 2 : 0);
    for (int i = 0; i < N; i++) begin
      ta = t - 4 - i;
      ea[8*i +: 8] = (m_v && ta >= 0 && ta < K) ? ja[ta][8*i +: 8] : 8'h00;
      eb[8*i +: 8] = (m_v && ta >= 0 && ta < K) ? jb[ta][8*i +: 8] : 8'h00;
    end
    chk("a_feed", a_feed, ea);
    chk("b_feed", b_feed, eb);
    if (!reset) m_v = 0;
    else if (!in_job && start) begin
      m_v = 1; m_s = cyc; ja = mem_a; jb = mem_b;
    end
  end

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      @(negedge clk);
      if (done) dc = cyc;
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse(output int s);
    @(posedge clk); #1 start = 1; s = cyc;
    @(posedge clk); #1 start = 0;
  endtask

  initial begin
    int s, dc, n, d [3];
    for (int k = 0; k < K; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
    @(posedge clk); run = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_arst", arst, 0);
    chk("rst_feed", a_feed, 0);
    @(posedge clk); #1 reset = 1;

    // single beat-0 pattern on A: lane i appears at s+4+i
    mem_a[0] = 32'h04030201;
    for (int k = 1; k < K; k++) mem_a[k] = '0;
    for (int k = 0; k < K; k++) mem_b[k] = $urandom;
    pulse(s);
    for (int t = 1; t <= L + 1; t++) begin
      @(negedge clk);
      if (t == 1) chk("clear_low", arst, 0);
      if (t == 2) chk("clear_high", arst, 1);
      if (t >= 2 && t <= 5) begin chk("rd_beat", rd_en, 1); chk("k_beat", k_addr, t - 2); end
      if (t == 6) chk("rd_off", rd_en, 0);
      for (int i = 0; i < N; i++) if (t == 4 + i) chk("a_lane", a_feed[8*i +: 8], i + 1);
      if (t == 13 || t == 15) chk("done_off", done, 0);
      if (t == 14) chk("done_s14", done, 1);
    end

    // identity times B: grid must reproduce B
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) begin
        mem_a[k][8*j +: 8] = (j == k) ? 8'd1 : 8'd0;
        mem_b[k][8*j +: 8] = 8'(4*k + j + 1);
      end
    pulse(s);
    wait_done(dc);
    chk("ident_lat", dc - s, 14);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk("ident_pe", g_grid[0].acc[r][c], 4*r + c + 1);
    repeat (3) @(negedge clk);
    chk("ident_hold", g_grid[0].acc[3][3], 16);

    // reset mid-FEED aborts the job
    for (int k = 0; k < K; k++) begin mem_a[k] = $urandom; mem_b[k] = $urandom; end
    pulse(s);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd", rd_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_feed", {a_feed, b_feed}, 0);
    chk("abort_arst", arst, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_arst", arst, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (done) n++; end
    chk("abort_no_done", n, 0);

    // start held high: back-to-back jobs K+2N+3 apart
    @(posedge clk); #1 start = 1;
    for (int j = 0; j < 3; j++) wait_done(d[j]);
    @(posedge clk); #1 start = 0;
    chk("gap01", d[1] - d[0], K + 2*N + 3);
    chk("gap12", d[2] - d[1], K + 2*N + 3);

    // K=1 with all operands 0xFF
    @(posedge clk); #1 start1 = 1; s = cyc;
    @(posedge clk); #1 start1 = 0;
    n = 0; dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      @(negedge clk);
      if (rd_en1) begin n++; chk("k1_addr", k_addr1, 0); end
      if (done1) dc = cyc;
    end
    chk("k1_reads", n, 1);
    chk("k1_lat", dc - s, 11);
    chk("k1_busy", busy1, 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk("k1_pe", g_grid[1].acc[r][c], 16'hFE01);
    repeat (5) @(negedge clk);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk("k1_hold", g_grid[1].acc[r][c], 16'hFE01);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
